rr_index_encoder: RTL and testbench

//   Round-robin request encoder that sits directly upstream of the 3-to-8 decoder.

---
 rtl/rr_index_encoder_pkg.sv | 15 +
 rtl/rr_index_encoder_pick.sv | 52 +++++
 rtl/rr_index_encoder.sv | 91 +++++++++
 tb/tb_rr_index_encoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_index_encoder_pkg.sv
// Shared types and helpers for the round-robin index encoder family.
package rr_index_encoder_pkg;

    // Offer FSM encoding, shared with the other encoder-family blocks.
    typedef enum logic {
        StIdle  = 1'b0,
        StOffer = 1'b1
    } rr_state_e;

    // Index width for n request lines; at least one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_index_encoder_pick.sv
// Combinational round-robin search: first set request at or after ptr, wrapping at N_REQ.
module rr_index_encoder_pick
    import rr_index_encoder_pkg::*;
#(
    parameter int unsigned N_REQ = 8,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   src;
    logic [IDX_W:0]   sum;

    // Rotate so that request ptr lands on bit 0; modulo done without a divider.
    always_comb begin
        rot = '0;
        src = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            src = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (src >= (IDX_W+1)'(N_REQ)) begin
                src = src - (IDX_W+1)'(N_REQ);
            end
            rot[i] = req_i[src[IDX_W-1:0]];
        end
    end

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        off     = '0;
        found_o = |rot;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    // Un-rotate: add ptr back, wrapping at N_REQ so idx never leaves 0..N_REQ-1.
    always_comb begin
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end
        idx_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/rr_index_encoder.sv
// Round-robin request encoder offering one binary index at a time over valid/ready.
module rr_index_encoder
    import rr_index_encoder_pkg::*;
#(
    parameter  int unsigned N_REQ = 8,
    localparam int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             idx_ready_i,
    output logic             idx_valid_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] ptr_dbg_o
);

    rr_state_e        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W:0]   idx_inc;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    // Search always starts from the pointer that will hold after this cycle, so a
    // transfer and the follow-up offer happen back to back.
    rr_index_encoder_pick #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_pick (
        .req_i  (req_i),
        .ptr_i  (ptr_d),
        .idx_o  (pick_idx),
        .found_o(pick_found)
    );

    assign idx_inc = {1'b0, idx_q} + (IDX_W+1)'(1);

    // Pointer advances past the accepted index on a transfer, wrapping to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StOffer && idx_ready_i) begin
            if (idx_inc == (IDX_W+1)'(N_REQ)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_inc[IDX_W-1:0];
            end
        end
    end

    // Offer FSM next state; an offer is never retracted until accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StOffer;
                    idx_d   = pick_idx;
                end
            end
            StOffer: begin
                if (idx_ready_i) begin
                    if (pick_found) begin
                        idx_d = pick_idx;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign idx_valid_o = (state_q == StOffer);
    assign idx_o       = idx_q;
    assign ptr_dbg_o   = ptr_q;

endmodule

// File: tb/tb_rr_index_encoder.sv
// Self-checking bench: directed table for N_REQ=8, directed N_REQ=5 run, randomized model check.
module tb_rr_index_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_a;
    logic       rdy_a;
    logic [4:0] req_b;
    logic       rdy_b;
    logic       v_a, v_b;
    logic [2:0] idx_a, ptr_a, idx_b, ptr_b;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference state per instance: 0 -> N_REQ=8, 1 -> N_REQ=5.
    int mv[2];
    int mi[2];
    int mp[2];

    typedef struct {
        logic       rs;
        logic [7:0] req;
        logic       rdy;
        int         v;
        int         i;
        int         p;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    rr_index_encoder #(.N_REQ(8)) u_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req_a),
        .idx_ready_i(rdy_a),
        .idx_valid_o(v_a),
        .idx_o      (idx_a),
        .ptr_dbg_o  (ptr_a)
    );

    rr_index_encoder #(.N_REQ(5)) u_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req_b),
        .idx_ready_i(rdy_b),
        .idx_valid_o(v_b),
        .idx_o      (idx_b),
        .ptr_dbg_o  (ptr_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First requesting line scanning ptr, ptr+1, ... modulo n.
    function automatic int pick(input int n, input int ptr, input logic [7:0] r);
        for (int k = 0; k < n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [7:0] onehot(input int m);
        logic [7:0] o;
        o = '0;
        for (int k = 0; k < 8; k++) begin
            if (k == m) o[k] = 1'b1;
        end
        return o;
    endfunction

    task automatic model_update(input int k, input int n, input logic [7:0] r,
                                input logic rdy, input logic rs);
        logic [7:0] rm;
        rm = r & 8'((1 << n) - 1);
        if (rs) begin
            mv[k] = 0;
            mi[k] = 0;
            mp[k] = 0;
        end else if (mv[k] == 0) begin
            if (rm != 0) begin
                mv[k] = 1;
                mi[k] = pick(n, mp[k], rm);
            end
        end else if (rdy) begin
            mp[k] = (mi[k] + 1) % n;
            if (rm != 0) mi[k] = pick(n, mp[k], rm);
            else mv[k] = 0;
        end
    endtask

    task automatic step(input logic rs, input logic [7:0] ra, input logic ya,
                        input logic [4:0] rb, input logic yb);
        logic [7:0] dec;
        rst   = rs;
        req_a = ra;
        rdy_a = ya;
        req_b = rb;
        rdy_b = yb;
        // Downstream 3-to-8 decoder output for a transfer about to happen.
        if (!rs && v_a === 1'b1 && ya) begin
            dec = 8'b1 << idx_a;
            chk("dec_a", int'(dec), int'(onehot(mi[0])));
        end
        @(posedge clk);
        model_update(0, 8, ra, ya, rs);
        model_update(1, 5, {3'b0, rb}, yb, rs);
        #1;
        chk("valid_a", int'(v_a), mv[0]);
        chk("idx_a", int'(idx_a), mi[0]);
        chk("ptr_a", int'(ptr_a), mp[0]);
        chk("valid_b", int'(v_b), mv[1]);
        chk("idx_b", int'(idx_b), mi[1]);
        chk("ptr_b", int'(ptr_b), mp[1]);
        chk("range_b", int'(idx_b < 3'd5 && ptr_b < 3'd5), 1);
    endtask

    task automatic add(input logic rs, input logic [7:0] r, input logic y,
                       input int v, input int i, input int p);
        vec_t t;
        t.rs  = rs;
        t.req = r;
        t.rdy = y;
        t.v   = v;
        t.i   = i;
        t.p   = p;
        tbl.push_back(t);
    endtask

    initial begin
        foreach (mv[k]) begin
            mv[k] = 0;
            mi[k] = 0;
            mp[k] = 0;
        end
        rst   = 1'b1;
        req_a = '0;
        rdy_a = 1'b0;
        req_b = '0;
        rdy_b = 1'b0;

        // Reset, then idle with no requests.
        add(1, 8'h00, 0, 0, 0, 0);
        add(1, 8'h00, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 8'h00, 0, 0, 0, 0);
        // Three requesters, ready held high: 2,5,7,2,5 then drain.
        add(0, 8'hA4, 1, 1, 2, 0);
        add(0, 8'hA4, 1, 1, 5, 3);
        add(0, 8'hA4, 1, 1, 7, 6);
        add(0, 8'hA4, 1, 1, 2, 0);
        add(0, 8'hA4, 1, 1, 5, 3);
        add(0, 8'h00, 1, 0, 5, 6);
        add(0, 8'h00, 0, 0, 5, 6);
        // Stalled offer holds even after the request drops.
        add(0, 8'h10, 0, 1, 4, 6);
        add(0, 8'h10, 0, 1, 4, 6);
        add(0, 8'h00, 0, 1, 4, 6);
        add(0, 8'h00, 0, 1, 4, 6);
        add(0, 8'h00, 1, 0, 4, 5);
        add(0, 8'h00, 0, 0, 4, 5);
        // Wrap between indices 0 and 7.
        add(1, 8'h00, 0, 0, 0, 0);
        add(0, 8'h81, 1, 1, 0, 0);
        add(0, 8'h81, 1, 1, 7, 1);
        add(0, 8'h81, 1, 1, 0, 0);
        add(0, 8'h81, 1, 1, 7, 1);
        add(0, 8'h81, 1, 1, 0, 0);
        // Reset during a live offer of index 3.
        add(0, 8'h08, 1, 1, 3, 1);
        add(1, 8'h08, 0, 0, 0, 0);
        add(0, 8'hFF, 0, 1, 0, 0);
        add(0, 8'hFF, 1, 1, 1, 1);

        foreach (tbl[n]) begin
            step(tbl[n].rs, tbl[n].req, tbl[n].rdy, 5'b0, 1'b0);
            chk("tbl_valid", int'(v_a), tbl[n].v);
            chk("tbl_idx", int'(idx_a), tbl[n].i);
            chk("tbl_ptr", int'(ptr_a), tbl[n].p);
        end

        // N_REQ=5 single top requester: index 4 every cycle, ptr stays at 0.
        step(1, 8'h00, 0, 5'b0, 0);
        for (int k = 0; k < 6; k++) begin
            step(0, 8'h00, 0, 5'b10000, 1);
            chk("n5_valid", int'(v_b), 1);
            chk("n5_idx", int'(idx_b), 4);
            chk("n5_ptr", int'(ptr_b), 0);
        end

        // Randomized traffic on both instances against the reference model.
        for (int k = 0; k < 3000; k++) begin
            logic       rs;
            logic [7:0] ra;
            logic [4:0] rb;
            rs = ($urandom_range(0, 63) == 0);
            ra = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom & $urandom);
            rb = ($urandom_range(0, 7) == 0) ? 5'h00 : 5'($urandom & $urandom);
            step(rs, ra, ($urandom_range(0, 3) != 0), rb, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
